// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw pad in, debounced level and event pulses out.
// The release event is named release_pulse because "release" is a reserved word.
interface button_conditioner_if;
    logic btn_in;
    logic btn_level;
    logic press;
    logic release_pulse;
    logic long_press;
    logic held_long;

    // Button/pad side drives btn_in and consumes the conditioned events.
    modport master (
        output btn_in,
        input  btn_level,
        input  press,
        input  release_pulse,
        input  long_press,
        input  held_long
    );

    // Conditioner side.
    modport slave (
        input  btn_in,
        output btn_level,
        output press,
        output release_pulse,
        output long_press,
        output held_long
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, press/release debounce FSM, optional long press.
// Define BUTTON_COND_LONGPRESS_EN to build long_press/held_long; otherwise both are tied low.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input logic                 clk,
    input logic                 rst_n,
    button_conditioner_if.slave btn
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("button_conditioner: LONG_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Synchroniser: only s2 is ever looked at by the FSM.
    always_comb begin
        s1_d = btn.btn_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES consecutive samples.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!s2_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn.btn_level     = level_q;
    assign btn.press         = press_q;
    assign btn.release_pulse = release_q;

`ifdef BUTTON_COND_LONGPRESS_EN
    localparam int unsigned LONG_W = $clog2(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_press_q, long_press_d;
    logic              held_long_q, held_long_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_q   <= '0;
            long_press_q <= 1'b0;
            held_long_q  <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_press_q <= long_press_d;
            held_long_q  <= held_long_d;
        end
    end

    // Hold timer: runs only while settled in PRESSED, frozen during release bounces.
    always_comb begin
        long_cnt_d   = long_cnt_q;
        long_press_d = 1'b0;
        held_long_d  = held_long_q;
        if (press_d) begin
            long_cnt_d = '0;
        end else if (state_q == ST_PRESSED) begin
            if (!held_long_q && (long_cnt_q == LONG_LAST)) begin
                long_press_d = 1'b1;
                held_long_d  = 1'b1;
            end else if (s2_q && (long_cnt_q != LONG_LAST)) begin
                long_cnt_d = long_cnt_q + LONG_W'(1);
            end
        end
        if (release_d) begin
            held_long_d = 1'b0;
        end
    end

    assign btn.long_press = long_press_q;
    assign btn.held_long  = held_long_q;
`else
    assign btn.long_press = 1'b0;
    assign btn.held_long  = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bounce runs against a run-length model.
module tb_button_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned LNG = 10;
`ifdef BUTTON_COND_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the pad is seen two edges late; level flips after DEB consecutive disagreeing samples.
    bit m_s1, m_s2, m_level, m_fired, m_press, m_rel, m_long;
    int m_run, m_age;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_fired = 0;
        m_press = 0; m_rel = 0; m_long = 0; m_run = 0; m_age = 0;
    endtask

    task automatic model_edge(input bit b);
        bit x;
        x = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        m_press = 0; m_rel = 0; m_long = 0;
        // Hold time accrues only while the level is high and no release is pending.
        if (LONG_EN && m_level && m_run == 0) begin
            if (!m_fired && m_age == int'(LNG) - 1) begin
                m_long = 1;
                m_fired = 1;
            end else if (x && m_age < int'(LNG) - 1) begin
                m_age++;
            end
        end
        if (x != m_level) begin
            m_run++;
            if (m_run == int'(DEB)) begin
                m_level = x;
                m_run = 0;
                if (x) begin
                    m_press = 1;
                    m_age = 0;
                end else begin
                    m_rel = 1;
                    m_fired = 0;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    int cyc = 0;
    int press_at, rel_at, long_at, press_n, rel_n, long_n, hi_n;

    task automatic clear_stats();
        press_at = -1; rel_at = -1; long_at = -1;
        press_n = 0; rel_n = 0; long_n = 0; hi_n = 0;
    endtask

    task automatic check_outputs();
        check_eq("btn_level", 32'(bif.btn_level), 32'(m_level));
        check_eq("press", 32'(bif.press), 32'(m_press));
        check_eq("release", 32'(bif.release_pulse), 32'(m_rel));
        check_eq("long_press", 32'(bif.long_press), 32'(m_long));
        check_eq("held_long", 32'(bif.held_long), 32'(m_fired));
    endtask

    // One clock: drive at negedge, model the posedge, compare at the next negedge.
    task automatic step(input bit b);
        bif.btn_in = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        check_outputs();
        if (bif.press === 1'b1) begin press_n++; if (press_at < 0) press_at = cyc; end
        if (bif.release_pulse === 1'b1) begin rel_n++; if (rel_at < 0) rel_at = cyc; end
        if (bif.long_press === 1'b1) begin long_n++; if (long_at < 0) long_at = cyc; end
        if (bif.btn_level === 1'b1) hi_n++;
        cyc++;
    endtask

    task automatic steps(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock.
    task automatic async_reset(input bit b);
        bif.btn_in = b;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_level", 32'(bif.btn_level), 32'd0);
        check_eq("rst_press", 32'(bif.press), 32'd0);
        check_eq("rst_release", 32'(bif.release_pulse), 32'd0);
        check_eq("rst_long", 32'(bif.long_press), 32'd0);
        check_eq("rst_held", 32'(bif.held_long), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    int base;

    initial begin
        rst_n = 1'b0;
        bif.btn_in = 1'b1;
        model_reset();
        clear_stats();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        check_outputs();

        // Button held through reset release: a fresh press five edges after first sample.
        rst_n = 1'b1;
        base = cyc;
        steps(1'b1, 12);
        check_eq("hold_thru_rst_press_lat", 32'(press_at - base), 32'd5);
        check_eq("hold_thru_rst_level", 32'(bif.btn_level), 32'd1);
        steps(1'b0, 10);

        // Short 2-cycle bounces never get through.
        clear_stats();
        for (int k = 0; k < 2; k++) begin
            steps(1'b1, 2);
            steps(1'b0, 2);
        end
        steps(1'b0, 8);
        check_eq("bounce_press_n", 32'(press_n), 32'd0);
        check_eq("bounce_rel_n", 32'(rel_n), 32'd0);
        check_eq("bounce_hi_n", 32'(hi_n), 32'd0);

        // Clean 6-cycle hold: symmetric latencies keep the level high for exactly 6 cycles.
        clear_stats();
        base = cyc;
        steps(1'b1, 6);
        steps(1'b0, 12);
        check_eq("clean_press_n", 32'(press_n), 32'd1);
        check_eq("clean_rel_n", 32'(rel_n), 32'd1);
        check_eq("clean_press_lat", 32'(press_at - base), 32'd5);
        check_eq("clean_rel_lat", 32'(rel_at - (base + 6)), 32'd5);
        check_eq("clean_hi_n", 32'(hi_n), 32'd6);

        // Long hold: one long_press, LNG edges after press.
        clear_stats();
        steps(1'b1, 20);
        check_eq("long_n", 32'(long_n), LONG_EN ? 32'd1 : 32'd0);
        if (LONG_EN) check_eq("long_lat", 32'(long_at - press_at), 32'(LNG));
        check_eq("long_held", 32'(bif.held_long), LONG_EN ? 32'd1 : 32'd0);
        steps(1'b0, 10);
        check_eq("long_rel_n", 32'(rel_n), 32'd1);
        check_eq("long_held_after_rel", 32'(bif.held_long), 32'd0);

        // Low glitch while pressed: no release, hold timer frozen for three edges.
        clear_stats();
        steps(1'b1, 8);
        steps(1'b0, 2);
        steps(1'b1, 16);
        check_eq("glitch_rel_n", 32'(rel_n), 32'd0);
        check_eq("glitch_level", 32'(bif.btn_level), 32'd1);
        if (LONG_EN) check_eq("glitch_long_lat", 32'(long_at - press_at), 32'(LNG + 3));
        steps(1'b0, 10);

        // Reset mid press-wait and mid pressed.
        steps(1'b1, 3);
        async_reset(1'b0);
        steps(1'b0, 4);
        steps(1'b1, 8);
        async_reset(1'b0);
        steps(1'b0, 6);

        // Random bounce runs with occasional long holds and async resets.
        for (int seg = 0; seg < 300; seg++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 16))
                                              : int'($urandom_range(1, 6));
            steps(lvl, len);
            if ($urandom_range(0, 49) == 0) async_reset(1'($urandom_range(0, 1)));
        end
        steps(1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
